// File: rtl/minmax_scan_ctrl.sv
// minmax_scan_ctrl: streams a burst of unsigned samples through one shared comparator
// and reports the burst max/min. Define MINMAX_INDEX_EN to add first-occurrence indices.
module minmax_scan_ctrl #(
   parameter int unsigned DATA_W = 4,
   parameter int unsigned CNT_W  = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [CNT_W-1:0]  len_i,
   input  logic              in_valid_i,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              in_ready_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              empty_o,
   output logic [DATA_W-1:0] max_out_o,
   output logic [DATA_W-1:0] min_out_o
`ifdef MINMAX_INDEX_EN
   ,
   output logic [CNT_W-1:0]  max_idx_o,
   output logic [CNT_W-1:0]  min_idx_o
`endif
);

   typedef enum logic [2:0] {IDLE, FETCH, CMP_HI, CMP_LO, FIN} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              first_q, first_d;
   logic [DATA_W-1:0] smp_q, smp_d;
   logic [DATA_W-1:0] max_q, max_d;
   logic [DATA_W-1:0] min_q, min_d;
   logic [DATA_W-1:0] maxOut_q, maxOut_d;
   logic [DATA_W-1:0] minOut_q, minOut_d;
   logic              empty_q, empty_d;
   logic [DATA_W-1:0] cmpY;
   logic              cmpGt, cmpLt;
`ifdef MINMAX_INDEX_EN
   logic [CNT_W-1:0]  pos_q, pos_d;
   logic [CNT_W-1:0]  smpIdx_q, smpIdx_d;
   logic [CNT_W-1:0]  maxIdx_q, maxIdx_d;
   logic [CNT_W-1:0]  minIdx_q, minIdx_d;
   logic [CNT_W-1:0]  maxIdxOut_q, maxIdxOut_d;
   logic [CNT_W-1:0]  minIdxOut_q, minIdxOut_d;
`endif

   // One comparator: its y operand follows whichever compare state is active.
   assign cmpY  = (state_q == CMP_HI) ? max_q : min_q;
   assign cmpGt = smp_q > cmpY;
   assign cmpLt = smp_q < cmpY;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      first_d  = first_q;
      smp_d    = smp_q;
      max_d    = max_q;
      min_d    = min_q;
      maxOut_d = maxOut_q;
      minOut_d = minOut_q;
      empty_d  = empty_q;
`ifdef MINMAX_INDEX_EN
      pos_d       = pos_q;
      smpIdx_d    = smpIdx_q;
      maxIdx_d    = maxIdx_q;
      minIdx_d    = minIdx_q;
      maxIdxOut_d = maxIdxOut_q;
      minIdxOut_d = minIdxOut_q;
`endif
      case (state_q)
         IDLE: begin
            if (start_i) begin
               if (len_i != '0) begin
                  state_d = FETCH;
                  cnt_d   = len_i;
                  first_d = 1'b1;
`ifdef MINMAX_INDEX_EN
                  pos_d   = '0;
`endif
               end else begin
                  state_d  = FIN;
                  maxOut_d = '0;
                  minOut_d = '0;
                  empty_d  = 1'b1;
`ifdef MINMAX_INDEX_EN
                  maxIdxOut_d = '0;
                  minIdxOut_d = '0;
`endif
               end
            end
         end
         FETCH: begin
            if (in_valid_i) begin
               cnt_d = cnt_q - CNT_W'(1);
`ifdef MINMAX_INDEX_EN
               pos_d = pos_q + CNT_W'(1);
`endif
               if (first_q) begin
                  max_d   = in_data_i;
                  min_d   = in_data_i;
                  first_d = 1'b0;
`ifdef MINMAX_INDEX_EN
                  maxIdx_d = '0;
                  minIdx_d = '0;
`endif
                  state_d = (cnt_q == CNT_W'(1)) ? FIN : FETCH;
               end else begin
                  smp_d   = in_data_i;
`ifdef MINMAX_INDEX_EN
                  smpIdx_d = pos_q;
`endif
                  state_d = CMP_HI;
               end
            end
         end
         CMP_HI: begin
            if (cmpGt) begin
               max_d = smp_q;
`ifdef MINMAX_INDEX_EN
               maxIdx_d = smpIdx_q;
`endif
            end
            state_d = CMP_LO;
         end
         CMP_LO: begin
            if (cmpLt) begin
               min_d = smp_q;
`ifdef MINMAX_INDEX_EN
               minIdx_d = smpIdx_q;
`endif
            end
            state_d = (cnt_q == '0) ? FIN : FETCH;
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Results are registered on entry to FIN so they are already valid while done is high.
      if ((state_d == FIN) && (state_q != IDLE)) begin
         maxOut_d = max_d;
         minOut_d = min_d;
         empty_d  = 1'b0;
`ifdef MINMAX_INDEX_EN
         maxIdxOut_d = maxIdx_d;
         minIdxOut_d = minIdx_d;
`endif
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         first_q  <= 1'b0;
         smp_q    <= '0;
         max_q    <= '0;
         min_q    <= '0;
         maxOut_q <= '0;
         minOut_q <= '0;
         empty_q  <= 1'b0;
`ifdef MINMAX_INDEX_EN
         pos_q       <= '0;
         smpIdx_q    <= '0;
         maxIdx_q    <= '0;
         minIdx_q    <= '0;
         maxIdxOut_q <= '0;
         minIdxOut_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         first_q  <= first_d;
         smp_q    <= smp_d;
         max_q    <= max_d;
         min_q    <= min_d;
         maxOut_q <= maxOut_d;
         minOut_q <= minOut_d;
         empty_q  <= empty_d;
`ifdef MINMAX_INDEX_EN
         pos_q       <= pos_d;
         smpIdx_q    <= smpIdx_d;
         maxIdx_q    <= maxIdx_d;
         minIdx_q    <= minIdx_d;
         maxIdxOut_q <= maxIdxOut_d;
         minIdxOut_q <= minIdxOut_d;
`endif
      end
   end

   assign in_ready_o = (state_q == FETCH);
   assign busy_o     = (state_q != IDLE);
   assign done_o     = (state_q == FIN);
   assign empty_o    = empty_q;
   assign max_out_o  = maxOut_q;
   assign min_out_o  = minOut_q;
`ifdef MINMAX_INDEX_EN
   assign max_idx_o  = maxIdxOut_q;
   assign min_idx_o  = minIdxOut_q;
`endif

endmodule

// File: tb/tb_minmax_scan_ctrl.sv
// tb_minmax_scan_ctrl: directed and randomized bursts checked against a queue-based max/min model.
// Define MINMAX_INDEX_EN to also check the first-occurrence index outputs.
module tb_minmax_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] len;
   logic       inValid;
   logic [3:0] inData;
   logic       inReady, busy, done, empty;
   logic [3:0] maxOut, minOut;
`ifdef MINMAX_INDEX_EN
   logic [3:0] maxIdx, minIdx;
`endif

   int vectors     = 0;
   int miscompares = 0;
   int doneCount   = 0;
   int readyCount  = 0;
   int samples[$];

   minmax_scan_ctrl #(.DATA_W(4), .CNT_W(4)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .start_i    (start),
      .len_i      (len),
      .in_valid_i (inValid),
      .in_data_i  (inData),
      .in_ready_o (inReady),
      .busy_o     (busy),
      .done_o     (done),
      .empty_o    (empty),
      .max_out_o  (maxOut),
      .min_out_o  (minOut)
`ifdef MINMAX_INDEX_EN
      ,
      .max_idx_o  (maxIdx),
      .min_idx_o  (minIdx)
`endif
   );

   always #5 clk = ~clk;

   // Pulse and handshake-window monitors, sampled away from the active edge.
   always @(negedge clk) begin
      if (done)    doneCount++;
      if (inReady) readyCount++;
   end

   task automatic checkOutput(input string tag, input int observed, input int expected);
      vectors++;
      if (observed != expected) begin
         miscompares++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Drives one burst from the samples queue and checks the result against the model.
   task automatic applyStimulus(input string name, input int burstLen,
                                input int gapMin, input int gapMax, input bit extraStart);
      int expMax, expMin, expMaxIdx, expMinIdx, lat, budget, gap;
      expMax = 0; expMin = 0; expMaxIdx = 0; expMinIdx = 0;
      for (int i = 0; i < samples.size(); i++) begin
         if (i == 0 || samples[i] > expMax) begin expMax = samples[i]; expMaxIdx = i; end
         if (i == 0 || samples[i] < expMin) begin expMin = samples[i]; expMinIdx = i; end
      end
      doneCount  = 0;
      readyCount = 0;
      @(negedge clk);
      start = 1'b1;
      len   = 4'(burstLen);
      @(negedge clk);
      start = 1'b0;
      len   = 4'($urandom);
      checkOutput({name, ".busy"}, int'(busy), 1);
      for (int i = 0; i < samples.size(); i++) begin
         gap = int'($urandom_range(gapMax, gapMin));
         repeat (gap) begin
            inValid = 1'b0;
            inData  = 4'($urandom);
            if (extraStart) start = 1'($urandom);
            @(negedge clk);
            start = 1'b0;
         end
         inValid = 1'b1;
         inData  = 4'(samples[i]);
         budget  = 0;
         while (!inReady && budget < 50) begin
            @(negedge clk);
            budget++;
         end
         if (budget >= 50) checkOutput({name, ".readyTimeout"}, 0, 1);
         @(negedge clk);
         inValid = 1'b0;
         inData  = 4'($urandom);
      end
      lat = 1;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      checkOutput({name, ".doneLatency"}, lat, (burstLen > 1) ? 3 : 1);
      checkOutput({name, ".max"}, int'(maxOut), expMax);
      checkOutput({name, ".min"}, int'(minOut), expMin);
      checkOutput({name, ".empty"}, int'(empty), (burstLen == 0) ? 1 : 0);
`ifdef MINMAX_INDEX_EN
      checkOutput({name, ".maxIdx"}, int'(maxIdx), expMaxIdx);
      checkOutput({name, ".minIdx"}, int'(minIdx), expMinIdx);
`endif
      if (burstLen == 0) checkOutput({name, ".readyNeverHigh"}, readyCount, 0);
      repeat (2) @(negedge clk);
      checkOutput({name, ".donePulses"}, doneCount, 1);
      checkOutput({name, ".busyAfter"}, int'(busy), 0);
      checkOutput({name, ".maxHeld"}, int'(maxOut), expMax);
      checkOutput({name, ".minHeld"}, int'(minOut), expMin);
   endtask

   // Reset lands while the second sample is in CMP_HI; results must vanish with no done.
   task automatic resetMidBurst();
      doneCount = 0;
      @(negedge clk);
      start = 1'b1;
      len   = 4'd4;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         inValid = 1'b1;
         inData  = (i == 0) ? 4'd6 : 4'd12;
         @(negedge clk);
      end
      inValid = 1'b0;
      rst = 1'b1;
      #1;
      checkOutput("T1.busy", int'(busy), 0);
      checkOutput("T1.inReady", int'(inReady), 0);
      checkOutput("T1.done", int'(done), 0);
      checkOutput("T1.max", int'(maxOut), 0);
      checkOutput("T1.min", int'(minOut), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      checkOutput("T1.noDone", doneCount, 0);
      checkOutput("T1.idleAfter", int'(busy), 0);
   endtask

   initial begin
      int burstLen;
      rst = 1'b1; start = 1'b0; len = '0; inValid = 1'b0; inData = '0;
      repeat (2) @(negedge clk);
      checkOutput("reset.busy", int'(busy), 0);
      checkOutput("reset.inReady", int'(inReady), 0);
      checkOutput("reset.done", int'(done), 0);
      checkOutput("reset.empty", int'(empty), 0);
      checkOutput("reset.max", int'(maxOut), 0);
      checkOutput("reset.min", int'(minOut), 0);
      rst = 1'b0;

      samples = '{3, 9, 1, 9};   applyStimulus("T2", 4, 0, 0, 1'b0);
      resetMidBurst();
      samples = '{7};            applyStimulus("T3", 1, 0, 0, 1'b0);
      samples = '{};             applyStimulus("T4", 0, 0, 0, 1'b0);
      samples = '{15, 0, 15};    applyStimulus("T5", 3, 2, 2, 1'b1);
      samples = '{5, 5};         applyStimulus("T6a", 2, 0, 0, 1'b0);
      samples = '{2, 14};        applyStimulus("T6b", 2, 0, 0, 1'b0);

      for (int b = 0; b < 30; b++) begin
         burstLen = ($urandom_range(7, 0) == 0) ? 15 : int'($urandom_range(6, 0));
         samples = '{};
         for (int i = 0; i < burstLen; i++) samples.push_back(int'($urandom_range(15, 0)));
         applyStimulus($sformatf("R%0d", b), burstLen, 0, 2, 1'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
